// File: rtl/hex_keypad_pkg.sv
// Shared types and helpers for the hex keypad encoder.
//   state_t    : debounce FSM states
//   scan_res_t : outcome of one full four-column scan
//   key_count  : number of pressed rows in one column sample, saturated at 2
//   row_index  : index of the lowest pressed row in one column sample
package hex_keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_t;

    function automatic logic [1:0] key_count(input logic [NUM_ROWS-1:0] pressed);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_ROWS); i++) begin
            n = n + {2'b00, pressed[i]};
        end
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    function automatic logic [1:0] row_index(input logic [NUM_ROWS-1:0] pressed);
        logic [1:0] idx;
        idx = '0;
        for (int i = int'(NUM_ROWS) - 1; i >= 0; i--) begin
            if (pressed[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_keypad_encoder_scanner.sv
// Keypad column scanner: divider, active-low column drive, two-flop row
// synchroniser and per-scan accumulation of pressed keys.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   row_i         : raw active-low row sense lines
//   col_o         : active-low one-hot column drive
//   scan_done_o   : one-cycle pulse on the column-3 sample edge
//   scan_res_o    : NONE / SINGLE / MULTI for the scan ending now
//   scan_code_o   : {row, col} of the key when scan_res_o is SINGLE
module keypad_scanner
    import hex_keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic      scan_done_o,
    output scan_res_t scan_res_o,
    output logic [3:0] scan_code_o
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [3:0]      row_meta_q, row_sync_q;
    logic [1:0]      acc_cnt_q, acc_cnt_d;
    logic [3:0]      acc_code_q, acc_code_d;

    logic       step;
    logic [3:0] pressed;
    logic [1:0] col_cnt, base_cnt, merged_cnt;
    logic [2:0] sum;
    logic [3:0] base_code, merged_code;

    always_comb begin
        step      = (div_q == DivLast);
        div_d     = step ? '0 : div_q + DivW'(1);
        col_idx_d = step ? col_idx_q + 2'd1 : col_idx_q;

        pressed = ~row_sync_q;
        col_cnt = key_count(pressed);

        // Column 0 opens a new scan, so earlier accumulation is dropped.
        base_cnt  = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
        base_code = (col_idx_q == 2'd0) ? 4'd0 : acc_code_q;

        sum         = {1'b0, base_cnt} + {1'b0, col_cnt};
        merged_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        // Code is only meaningful when merged_cnt is 1, i.e. one side holds it.
        merged_code = (col_cnt != 2'd0) ? {row_index(pressed), col_idx_q} : base_code;

        acc_cnt_d  = step ? merged_cnt : acc_cnt_q;
        acc_code_d = step ? merged_code : acc_code_q;

        scan_done_o = step && (col_idx_q == 2'd3);
        scan_code_o = merged_code;
        if (merged_cnt == 2'd0) begin
            scan_res_o = NONE;
        end else if (merged_cnt == 2'd1) begin
            scan_res_o = SINGLE;
        end else begin
            scan_res_o = MULTI;
        end

        col_o = ~(4'b0001 << col_idx_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q      <= '0;
            col_idx_q  <= 2'd0;
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else begin
            div_q      <= div_d;
            col_idx_q  <= col_idx_d;
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

endmodule

// File: rtl/hex_keypad_encoder.sv
// 4x4 hex keypad encoder: scans the matrix, debounces presses and releases
// over DEBOUNCE_SCANS full scans and reports a 4-bit key code.
//   Clk, ResetN : clock, asynchronous active-low reset
//   Row         : raw active-low row sense lines (asynchronous)
//   Col         : active-low one-hot column drive
//   KeyCode     : last accepted key {row, col}
//   KeyValid    : one-cycle pulse on each accepted press
//   KeyHeld     : accepted key still considered pressed
//   MultiKey    : last full scan saw two or more keys
module hex_keypad_encoder
    import hex_keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] KeyCode,
    output logic       KeyValid,
    output logic       KeyHeld,
    output logic       MultiKey
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_SCANS);

    logic       scan_done;
    scan_res_t  scan_res;
    logic [3:0] scan_code;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk_i       (Clk),
        .rst_ni      (ResetN),
        .row_i       (Row),
        .col_o       (Col),
        .scan_done_o (scan_done),
        .scan_res_o  (scan_res),
        .scan_code_o (scan_code)
    );

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            multi_key_q, multi_key_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        multi_key_d = multi_key_q;
        cnt_inc     = cnt_q + CntW'(1);

        if (scan_done) begin
            multi_key_d = (scan_res == MULTI);
            case (state_q)
                IDLE: begin
                    if (scan_res == SINGLE) begin
                        cand_d = scan_code;
                        cnt_d  = CntW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d     = PRESSED;
                            key_code_d  = scan_code;
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (scan_res == SINGLE && scan_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntDone) begin
                            state_d     = PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                        end
                    end else if (scan_res == SINGLE) begin
                        cand_d = scan_code;
                        cnt_d  = CntW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    // Any key activity, even a different key, keeps the press alive.
                    if (scan_res == NONE) begin
                        cnt_d   = CntW'(1);
                        state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (scan_res == NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntDone) begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            multi_key_q <= multi_key_d;
        end
    end

    assign KeyCode  = key_code_q;
    assign KeyValid = key_valid_q;
    assign KeyHeld  = (state_q == PRESSED) || (state_q == RELEASE);
    assign MultiKey = multi_key_q;

endmodule

// File: tb/tb_hex_keypad_encoder.sv
// Self-checking bench for hex_keypad_encoder (SCAN_DIV = 4, DEBOUNCE_SCANS = 2).
// A keypad model turns a 16-bit pressed-key set (bit r*4+c) into Row levels for
// the currently driven column. Key sets change only at scan boundaries.
module tb_hex_keypad_encoder;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned SCAN_LEN = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid, key_held, multi_key;
    logic [15:0] keys = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hex_keypad_encoder #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .Clk      (clk),
        .ResetN   (rst_n),
        .Row      (row),
        .Col      (col),
        .KeyCode  (key_code),
        .KeyValid (key_valid),
        .KeyHeld  (key_held),
        .MultiKey (multi_key)
    );

    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (col[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r*4+c]) row[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_col(input int idx);
        logic [3:0] v;
        v = 4'hF;
        v[idx] = 1'b0;
        return v;
    endfunction

    // Reference model: press accepted when the last DEB scans since going idle
    // all saw the same single key; release when DEB consecutive empty scans.
    bit         m_held;
    int         m_hist[$];
    int         m_none;
    logic [3:0] m_code;

    task automatic model_reset();
        m_held = 1'b0;
        m_hist.delete();
        m_none = 0;
        m_code = 4'h0;
    endtask

    task automatic model_scan(input logic [15:0] k, output logic ev, output logic [3:0] ec,
                              output logic eh, output logic em);
        int res;
        int run;
        res = -1;
        if ($countones(k) > 1) begin
            res = -2;
        end else if ($countones(k) == 1) begin
            for (int i = 0; i < 16; i++) if (k[i]) res = i;
        end
        ev = 1'b0;
        if (!m_held) begin
            m_hist.push_back(res);
            run = 0;
            if (res >= 0) begin
                for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] == res; i--) run++;
            end
            if (res >= 0 && run == int'(DEB)) begin
                m_held = 1'b1;
                m_code = res[3:0];
                ev     = 1'b1;
                m_hist.delete();
                m_none = 0;
            end
        end else begin
            if (res == -1) m_none++;
            else m_none = 0;
            if (m_none == int'(DEB)) begin
                m_held = 1'b0;
                m_none = 0;
            end
        end
        ec = m_code;
        eh = m_held;
        em = (res == -2);
    endtask

    // Entered on the negedge just after a scan-end edge (or reset release).
    task automatic run_scan(input logic [15:0] k, input logic ev, input logic [3:0] ec,
                            input logic eh, input logic em);
        keys = k;
        for (int j = 0; j < int'(SCAN_LEN); j++) begin
            if (j > 0) begin
                @(negedge clk);
                chk("stray_valid", {3'b000, key_valid}, 4'h0);
            end
            chk("col", col, exp_col(j / int'(SCAN_DIV)));
        end
        @(negedge clk);
        chk("valid", {3'b000, key_valid}, {3'b000, ev});
        chk("code", key_code, ec);
        chk("held", {3'b000, key_held}, {3'b000, eh});
        chk("multi", {3'b000, multi_key}, {3'b000, em});
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_code_now", key_code, 4'h0);
        chk("rst_col_now", col, 4'b1110);
        chk("rst_held_now", {3'b000, key_held}, 4'h0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_col", col, 4'b1110);
            chk("rst_outs", {key_valid, key_held, multi_key, 1'b0}, 4'h0);
            chk("rst_code", key_code, 4'h0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] keys;
        logic        v;
        logic [3:0]  c;
        logic        h;
        logic        m;
    } vec_t;

    vec_t tbl[26];

    initial begin
        logic        ev, eh, em;
        logic [3:0]  ec;
        logic [15:0] cur;
        int          a, b, sel;

        // bounce
        tbl[0]  = '{16'h0001, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{16'h0000, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[2]  = '{16'h0000, 1'b0, 4'h0, 1'b0, 1'b0};
        // single press of key 9, six scans, then release
        tbl[3]  = '{16'h0200, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[4]  = '{16'h0200, 1'b1, 4'h9, 1'b1, 1'b0};
        tbl[5]  = '{16'h0200, 1'b0, 4'h9, 1'b1, 1'b0};
        tbl[6]  = '{16'h0200, 1'b0, 4'h9, 1'b1, 1'b0};
        tbl[7]  = '{16'h0200, 1'b0, 4'h9, 1'b1, 1'b0};
        tbl[8]  = '{16'h0200, 1'b0, 4'h9, 1'b1, 1'b0};
        tbl[9]  = '{16'h0000, 1'b0, 4'h9, 1'b1, 1'b0};
        tbl[10] = '{16'h0000, 1'b0, 4'h9, 1'b0, 1'b0};
        tbl[11] = '{16'h0000, 1'b0, 4'h9, 1'b0, 1'b0};
        // multiple keys (0,0)+(3,3), then only (3,3)
        tbl[12] = '{16'h8001, 1'b0, 4'h9, 1'b0, 1'b1};
        tbl[13] = '{16'h8001, 1'b0, 4'h9, 1'b0, 1'b1};
        tbl[14] = '{16'h8000, 1'b0, 4'h9, 1'b0, 1'b0};
        tbl[15] = '{16'h8000, 1'b1, 4'hF, 1'b1, 1'b0};
        // release glitch, then a different key while held
        tbl[16] = '{16'h0000, 1'b0, 4'hF, 1'b1, 1'b0};
        tbl[17] = '{16'h8000, 1'b0, 4'hF, 1'b1, 1'b0};
        tbl[18] = '{16'h0008, 1'b0, 4'hF, 1'b1, 1'b0};
        tbl[19] = '{16'h0000, 1'b0, 4'hF, 1'b1, 1'b0};
        tbl[20] = '{16'h0000, 1'b0, 4'hF, 1'b0, 1'b0};
        // candidate restart: key 1 then key 2
        tbl[21] = '{16'h0002, 1'b0, 4'hF, 1'b0, 1'b0};
        tbl[22] = '{16'h0004, 1'b0, 4'hF, 1'b0, 1'b0};
        tbl[23] = '{16'h0004, 1'b1, 4'h2, 1'b1, 1'b0};
        tbl[24] = '{16'h0000, 1'b0, 4'h2, 1'b1, 1'b0};
        tbl[25] = '{16'h0000, 1'b0, 4'h2, 1'b0, 1'b0};

        do_reset(5);
        for (int i = 0; i < 26; i++) begin
            run_scan(tbl[i].keys, tbl[i].v, tbl[i].c, tbl[i].h, tbl[i].m);
        end

        // Reset mid-debounce on key (1,2)
        run_scan(16'h0040, 1'b0, 4'h2, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        do_reset(5);
        run_scan(16'h0040, 1'b0, 4'h0, 1'b0, 1'b0);
        run_scan(16'h0040, 1'b1, 4'h6, 1'b1, 1'b0);
        run_scan(16'h0000, 1'b0, 4'h6, 1'b1, 1'b0);
        run_scan(16'h0000, 1'b0, 4'h6, 1'b0, 1'b0);

        // Randomized scans against the reference model
        do_reset(3);
        cur = 16'h0000;
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 9) >= 6) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 3) begin
                    cur = 16'h0000;
                end else if (sel < 8) begin
                    cur = 16'h0001 << $urandom_range(0, 15);
                end else begin
                    a   = int'($urandom_range(0, 15));
                    b   = (a + 1 + int'($urandom_range(0, 14))) % 16;
                    cur = (16'h0001 << a) | (16'h0001 << b);
                end
            end
            model_scan(cur, ev, ec, eh, em);
            run_scan(cur, ev, ec, eh, em);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
